// File: rtl/display_scanner.sv
// Shares one datapath issue slot between host instructions and a raster DISPLAY scan, forwarding scan colours as VGA plots.
// Build with HOST_PRIORITY_EN defined to let host requests always win arbitration; the default is round-robin.
module display_scanner #(
    parameter int SCREEN_WIDTH      = 160,
    parameter int SCREEN_HEIGHT     = 120,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int OPCODE_WIDTH      = 4,
    parameter logic [OPCODE_WIDTH-1:0] OPCODE_DISPLAY = OPCODE_WIDTH'(3)
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         enable,
    input  logic                         host_req,
    input  logic [INSTRUCTION_WIDTH-1:0] host_instruction,
    output logic                         host_grant,
    output logic                         host_done,
    output logic                         dp_start,
    output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
    input  logic                         dp_finished,
    input  logic [2:0]                   dp_colour,
    output logic [7:0]                   vga_x,
    output logic [6:0]                   vga_y,
    output logic [2:0]                   vga_colour,
    output logic                         vga_plot,
    output logic                         frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DROP,
        WAIT_DONE,
        PLOT
    } state_t;

    typedef enum logic {
        OWNER_SCANNER,
        OWNER_HOST
    } owner_t;

    localparam logic [7:0] X_LAST = 8'(SCREEN_WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_HEIGHT - 1);

    state_t                         state;
    owner_t                         owner;
    logic [7:0]                     x;
    logic [6:0]                     y;
    logic                           host_wins;
    logic [INSTRUCTION_WIDTH-1:0]   display_instruction;

    always_comb begin
        display_instruction = '0;
        display_instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] = OPCODE_DISPLAY;
        display_instruction[14:8] = y;
        display_instruction[7:0]  = x;
    end

    // owner doubles as the last-owner flag, so the side that did not go last wins a tie
`ifdef HOST_PRIORITY_EN
    assign host_wins = host_req;
`else
    assign host_wins = host_req && (!enable || owner == OWNER_SCANNER);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            owner          <= OWNER_HOST;
            x              <= '0;
            y              <= '0;
            dp_start       <= 1'b0;
            dp_instruction <= '0;
            host_grant     <= 1'b0;
            host_done      <= 1'b0;
            vga_x          <= '0;
            vga_y          <= '0;
            vga_colour     <= '0;
            vga_plot       <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            dp_start   <= 1'b0;
            host_grant <= 1'b0;
            host_done  <= 1'b0;
            vga_plot   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dp_finished) begin
                        if (host_wins) begin
                            owner          <= OWNER_HOST;
                            dp_instruction <= host_instruction;
                            host_grant     <= 1'b1;
                            dp_start       <= 1'b1;
                            state          <= ISSUE;
                        end else if (enable) begin
                            owner          <= OWNER_SCANNER;
                            dp_instruction <= display_instruction;
                            dp_start       <= 1'b1;
                            state          <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_DROP;
                end
                // finished must fall before its rise can be trusted as completion
                WAIT_DROP: begin
                    if (!dp_finished) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (dp_finished) begin
                        if (owner == OWNER_HOST) begin
                            host_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            vga_colour <= dp_colour;
                            vga_x      <= x;
                            vga_y      <= y;
                            vga_plot   <= 1'b1;
                            frame_done <= (x == X_LAST) && (y == Y_LAST);
                            state      <= PLOT;
                        end
                    end
                end
                PLOT: begin
                    if (x != X_LAST) begin
                        x <= x + 8'd1;
                    end else begin
                        x <= '0;
                        y <= (y == Y_LAST) ? 7'd0 : y + 7'd1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner on a 4x2 screen with a behavioural datapath model.
// Scenarios cover the frame scan, host interleave, idle scanning, async reset and slow finish drop.
module tb_display_scanner;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       frame;
    } plot_t;

    localparam logic [31:0] HOST_A = 32'h2000_1234;
    localparam logic [31:0] HOST_B = 32'h2000_5678;
    localparam logic [31:0] HOST_C = 32'h1000_00AA;
    localparam logic [31:0] HOST_D = 32'h1000_00BB;

    logic        clock = 1'b0;
    logic        resetn;
    logic        enable;
    logic        host_req;
    logic [31:0] host_instruction;
    logic        host_grant;
    logic        host_done;
    logic        dp_start;
    logic [31:0] dp_instruction;
    logic        dp_finished;
    logic [2:0]  dp_colour;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int grant_cnt = 0;
    int done_cnt = 0;
    int starts_while_busy = 0;
    int stray_frame = 0;
    plot_t       plot_q[$];
    int          plot_cyc[$];
    logic [31:0] start_q[$];
    int          start_cyc[$];

    int          dp_delay = 2;
    int          dp_hold = 0;
    logic        dp_force_busy = 1'b0;
    logic        model_fin;
    logic        m_busy;
    int          m_hold;
    int          m_run;
    logic [31:0] m_instr;

    display_scanner #(
        .SCREEN_WIDTH (4),
        .SCREEN_HEIGHT(2)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .enable          (enable),
        .host_req        (host_req),
        .host_instruction(host_instruction),
        .host_grant      (host_grant),
        .host_done       (host_done),
        .dp_start        (dp_start),
        .dp_instruction  (dp_instruction),
        .dp_finished     (dp_finished),
        .dp_colour       (dp_colour),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_colour      (vga_colour),
        .vga_plot        (vga_plot),
        .frame_done      (frame_done)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] colourOf(input logic [31:0] instr);
        return 3'(instr[2:0] + {instr[9:8], 1'b0} + 3'd1);
    endfunction

    function automatic logic [31:0] dispInstr(input logic [7:0] px, input logic [6:0] py);
        return {4'd3, 13'd0, py, px};
    endfunction

    // Datapath: optionally keeps finished high for dp_hold cycles, then low for dp_delay cycles
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_busy    <= 1'b0;
            m_hold    <= 0;
            m_run     <= 0;
            m_instr   <= '0;
            model_fin <= 1'b1;
            dp_colour <= '0;
        end else if (dp_start && !m_busy) begin
            m_busy  <= 1'b1;
            m_instr <= dp_instruction;
            m_hold  <= dp_hold;
            m_run   <= dp_delay;
            if (dp_hold == 0) model_fin <= 1'b0;
        end else if (m_busy) begin
            if (m_hold > 0) begin
                m_hold <= m_hold - 1;
                if (m_hold == 1) model_fin <= 1'b0;
            end else if (m_run > 1) begin
                m_run <= m_run - 1;
            end else begin
                m_busy    <= 1'b0;
                model_fin <= 1'b1;
                dp_colour <= colourOf(m_instr);
            end
        end
    end

    assign dp_finished = model_fin && !dp_force_busy;

    always @(negedge clock) begin
        if (dp_start) begin
            start_q.push_back(dp_instruction);
            start_cyc.push_back(cycle);
            if (m_busy) starts_while_busy++;
        end
        if (vga_plot) begin
            plot_q.push_back({vga_x, vga_y, vga_colour, frame_done});
            plot_cyc.push_back(cycle);
        end
        if (frame_done && !vga_plot) stray_frame++;
        if (host_grant) grant_cnt++;
        if (host_done) done_cnt++;
        cycle++;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic req, input logic [31:0] instr);
        enable           = en;
        host_req         = req;
        host_instruction = instr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearLog();
        plot_q.delete();
        plot_cyc.delete();
        start_q.delete();
        start_cyc.delete();
        grant_cnt = 0;
        done_cnt = 0;
        starts_while_busy = 0;
        stray_frame = 0;
    endtask

    task automatic doReset();
        resetn = 1'b0;
        repeat (3) tick();
        clearLog();
        resetn = 1'b1;
    endtask

    task automatic waitPlots(input int n, input string name);
        for (int i = 0; i < 400 && plot_q.size() < n; i++) tick();
        checkOutput(name, 32'(plot_q.size()), 32'(n));
    endtask

    task automatic waitStarts(input int n, input string name);
        for (int i = 0; i < 400 && start_q.size() < n; i++) tick();
        checkOutput(name, 32'(start_q.size()), 32'(n));
    endtask

    task automatic waitGrants(input int n, input string name);
        for (int i = 0; i < 400 && grant_cnt < n; i++) tick();
        checkOutput(name, 32'(grant_cnt), 32'(n));
    endtask

    task automatic waitDones(input int n, input string name);
        for (int i = 0; i < 400 && done_cnt < n; i++) tick();
        checkOutput(name, 32'(done_cnt), 32'(n));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " dp_start"}, 32'(dp_start), 32'd0);
        checkOutput({tag, " dp_instruction"}, dp_instruction, 32'd0);
        checkOutput({tag, " vga_x"}, 32'(vga_x), 32'd0);
        checkOutput({tag, " vga_y"}, 32'(vga_y), 32'd0);
        checkOutput({tag, " vga_colour"}, 32'(vga_colour), 32'd0);
        checkOutput({tag, " vga_plot"}, 32'(vga_plot), 32'd0);
        checkOutput({tag, " host_grant"}, 32'(host_grant), 32'd0);
        checkOutput({tag, " host_done"}, 32'(host_done), 32'd0);
        checkOutput({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        plot_t       frame_table[9];
        logic [31:0] rr_table[6];

        // colour = x + 2y + 1 (mod 8) from the datapath model
        frame_table[0] = {8'd0, 7'd0, 3'd1, 1'b0};
        frame_table[1] = {8'd1, 7'd0, 3'd2, 1'b0};
        frame_table[2] = {8'd2, 7'd0, 3'd3, 1'b0};
        frame_table[3] = {8'd3, 7'd0, 3'd4, 1'b0};
        frame_table[4] = {8'd0, 7'd1, 3'd3, 1'b0};
        frame_table[5] = {8'd1, 7'd1, 3'd4, 1'b0};
        frame_table[6] = {8'd2, 7'd1, 3'd5, 1'b0};
        frame_table[7] = {8'd3, 7'd1, 3'd6, 1'b1};
        frame_table[8] = {8'd0, 7'd0, 3'd1, 1'b0};

`ifdef HOST_PRIORITY_EN
        rr_table = '{HOST_A, HOST_B, 32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h3000_0003};
`else
        rr_table = '{32'h3000_0000, HOST_A, 32'h3000_0001, HOST_B, 32'h3000_0002, 32'h3000_0003};
`endif

        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0);
        repeat (2) tick();
        $display("[TB] reset state");
        checkAllZero("reset");

        $display("[TB] full frame scan");
        applyStimulus(1'b1, 1'b0, 32'd0);
        doReset();
        waitPlots(9, "frame plot count");
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("frame[%0d] x", i), 32'(plot_q[i].x), 32'(frame_table[i].x));
            checkOutput($sformatf("frame[%0d] y", i), 32'(plot_q[i].y), 32'(frame_table[i].y));
            checkOutput($sformatf("frame[%0d] colour", i), 32'(plot_q[i].colour), 32'(frame_table[i].colour));
            checkOutput($sformatf("frame[%0d] frame_done", i), 32'(plot_q[i].frame), 32'(frame_table[i].frame));
            checkOutput($sformatf("frame[%0d] instr", i), start_q[i],
                        dispInstr(frame_table[i].x, frame_table[i].y));
        end
        checkOutput("frame start count", 32'(start_q.size()), 32'd9);
        checkOutput("frame latency", 32'(plot_cyc[0] - start_cyc[0]), 32'd4);
        checkOutput("frame stray frame_done", 32'(stray_frame), 32'd0);

        $display("[TB] host interleave");
        applyStimulus(1'b1, 1'b1, HOST_A);
        doReset();
        waitGrants(1, "host first grant");
        host_instruction = HOST_B;
        waitGrants(2, "host second grant");
        host_req = 1'b0;
        waitStarts(6, "interleave start count");
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("interleave instr[%0d]", i), start_q[i], rr_table[i]);
        end
        repeat (30) tick();
        checkOutput("interleave grants after drop", 32'(grant_cnt), 32'd2);
        checkOutput("interleave host_done count", 32'(done_cnt), 32'd2);

        $display("[TB] host only with scanning disabled");
        applyStimulus(1'b0, 1'b1, HOST_C);
        doReset();
        waitGrants(1, "idle-scan grant 1");
        host_req = 1'b0;
        waitDones(1, "idle-scan done 1");
        applyStimulus(1'b0, 1'b1, HOST_D);
        waitGrants(2, "idle-scan grant 2");
        host_req = 1'b0;
        waitDones(2, "idle-scan done 2");
        repeat (10) tick();
        checkOutput("idle-scan plot count", 32'(plot_q.size()), 32'd0);
        checkOutput("idle-scan instr 0", start_q[0], HOST_C);
        checkOutput("idle-scan instr 1", start_q[1], HOST_D);
        dp_force_busy = 1'b1;
        enable = 1'b1;
        repeat (12) tick();
        checkOutput("busy datapath blocks issue", 32'(start_q.size()), 32'd2);
        dp_force_busy = 1'b0;
        waitPlots(1, "re-enable plot count");
        checkOutput("re-enable instr", start_q[2], dispInstr(8'd0, 7'd0));
        checkOutput("re-enable plot x", 32'(plot_q[0].x), 32'd0);
        checkOutput("re-enable plot y", 32'(plot_q[0].y), 32'd0);

        $display("[TB] async reset in WAIT_DONE");
        applyStimulus(1'b1, 1'b0, 32'd0);
        doReset();
        waitPlots(2, "pre-reset plot count");
        dp_delay = 6;
        waitStarts(3, "pre-reset start count");
        repeat (3) tick();
        checkOutput("pre-reset vga_x", 32'(vga_x), 32'd1);
        checkOutput("pre-reset vga_colour", 32'(vga_colour), 32'd2);
        resetn = 1'b0;
        #1;
        checkAllZero("async reset");
        repeat (2) tick();
        clearLog();
        dp_delay = 2;
        resetn = 1'b1;
        waitPlots(1, "post-reset plot count");
        checkOutput("post-reset instr", start_q[0], dispInstr(8'd0, 7'd0));
        checkOutput("post-reset plot x", 32'(plot_q[0].x), 32'd0);
        checkOutput("post-reset plot y", 32'(plot_q[0].y), 32'd0);
        checkOutput("post-reset host_done", 32'(done_cnt), 32'd0);

        $display("[TB] slow finished drop");
        dp_hold = 3;
        applyStimulus(1'b1, 1'b0, 32'd0);
        doReset();
        waitPlots(2, "hold plot count");
        checkOutput("hold start count", 32'(start_q.size()), 32'd2);
        checkOutput("hold start while busy", 32'(starts_while_busy), 32'd0);
        checkOutput("hold latency", 32'(plot_cyc[0] - start_cyc[0]), 32'd7);
        checkOutput("hold plot 1 x", 32'(plot_q[1].x), 32'd1);
        dp_hold = 0;

`ifdef HOST_PRIORITY_EN
        $display("[TB] host priority starvation");
        applyStimulus(1'b1, 1'b1, HOST_A);
        doReset();
        waitGrants(5, "priority grant count");
        host_req = 1'b0;
        checkOutput("priority plot count", 32'(plot_q.size()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("priority instr[%0d]", i), start_q[i], HOST_A);
        end
        waitPlots(1, "priority resume plot count");
        checkOutput("priority resume x", 32'(plot_q[0].x), 32'd0);
        checkOutput("priority resume y", 32'(plot_q[0].y), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Sits between the system controller and the instruction datapath.
- Owns the datapath's start/instruction/finished handshake.
- Continuously walks the framebuffer, issuing a DISPLAY instruction per pixel and forwarding the returned colour to the VGA adapter as a one-cycle plot.
- Interleaves host instructions (DRAW/MEMREAD/MEMWRITE) from the controller into the same issue slot.

Parameters:
- SCREEN_WIDTH, 160, pixels per row; x range 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 120, rows; y range 0..SCREEN_HEIGHT-1.
- INSTRUCTION_WIDTH, 32, datapath instruction width.
- OPCODE_WIDTH, 4, opcode field width; the opcode occupies the top OPCODE_WIDTH bits.
- OPCODE_DISPLAY, 4'd3, DISPLAY opcode value; the top level overrides it from the shared constants.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset; shared with the datapath.
- enable  in  1  scanning allowed; host traffic is served regardless.
- host_req  in  1  host instruction pending; held until host_grant.
- host_instruction  in  INSTRUCTION_WIDTH  host instruction, sampled on the grant cycle.
- host_grant  out  1  one-cycle pulse: host instruction latched and issued.
- host_done  out  1  one-cycle pulse: host instruction completed.
- dp_start  out  1  datapath start strobe.
- dp_instruction  out  INSTRUCTION_WIDTH  instruction presented with dp_start.
- dp_finished  in  1  datapath idle/complete flag.
- dp_colour  in  3  datapath colour output, valid when a DISPLAY completes.
- vga_x  out  8  plot x.
- vga_y  out  7  plot y.
- vga_colour  out  3  plot colour.
- vga_plot  out  1  one-cycle plot strobe.
- frame_done  out  1  one-cycle pulse coinciding with the plot of the last pixel.

Behaviour:
- Reset (async, resetn=0):
  - FSM goes to IDLE; pixel counters x=0, y=0.
  - Last-owner flag = HOST, so the scanner wins the first tie.
  - All outputs are 0: dp_start, dp_instruction, vga_*, host_grant, host_done, frame_done.
  - Reset mid-operation abandons the in-flight instruction with no done/plot pulse.
- States: IDLE, ISSUE, WAIT_DROP, WAIT_DONE, PLOT.
- IDLE (waits for dp_finished=1), arbitration:
  - Candidates are host_req, and enable for the scanner.
  - Both candidates present: the owner opposite to last-owner wins (round robin).
  - A single candidate wins outright.
  - The winner is registered as owner.
  - Host win: latch host_instruction, pulse host_grant.
  - Scanner win: dp_instruction = {OPCODE_DISPLAY, zero fill, y[6:0] at [14:8], x[7:0] at [7:0]}.
  - Next state ISSUE.
- ISSUE: dp_start=1 for exactly this one cycle; dp_instruction held stable → WAIT_DROP.
- WAIT_DROP: remain until dp_finished=0 → WAIT_DONE.
- WAIT_DONE: remain until dp_finished=1.
  - Owner HOST: pulse host_done → IDLE.
  - Owner SCANNER: capture vga_colour=dp_colour, vga_x=x, vga_y=y → PLOT.
- PLOT: vga_plot=1 for one cycle, then advance the counters → IDLE.
  - If x<SCREEN_WIDTH-1: x+1.
  - Else x=0; y=y+1, wrapping to 0 after SCREEN_HEIGHT-1.
  - frame_done=1 in the same cycle when (x,y) was (SCREEN_WIDTH-1, SCREEN_HEIGHT-1).
- vga_x/vga_y/vga_colour hold their value between plots.
- Latency: for a datapath DISPLAY taking D cycles after start, the plot occurs at IDLE + D + 3 cycles minimum.
- Counters never leave range; no out-of-range DISPLAY is ever issued.
- enable dropped mid-scan: the in-flight pixel completes and plots. Counters freeze and resume from the same pixel when enable returns.
- host_req and enable both 0: stay in IDLE, no activity.
- dp_finished=0 while in IDLE (datapath busy from before reset release): no issue until it reads 1.

Optional Feature:
- HOST_PRIORITY_EN defined: host_req always wins arbitration in IDLE. Scanning proceeds only when host_req=0, so the host can starve the scanner.
- HOST_PRIORITY_EN undefined: round-robin as above; neither side waits more than one operation.

Test Plan:
- SCREEN_WIDTH=4, SCREEN_HEIGHT=2, enable=1, datapath model with D=2:
  - 8 plots in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), each with the modelled colour.
  - frame_done only on the (3,1) plot; the next plot is (0,0).
  - Exactly one dp_start cycle per pixel; dp_instruction[7:0]=x, [14:8]=y, top 4 bits = 3.
- host_req held with host_instruction=32'h2000_1234 during scanning:
  - Grants alternate scanner/host.
  - Datapath receives 32'h2000_1234 verbatim.
  - host_done pulses once; host_req dropped after grant → no second grant.
- enable=0 with host_req pulses only → no vga_plot, counters stay (0,0); re-enable → first plot at (0,0).
- resetn asserted in WAIT_DONE → all outputs 0 immediately (asynchronous). After release, the first DISPLAY issued is for (0,0) and no stale plot or host_done appears.
- Datapath model holding dp_finished=1 for 3 extra cycles after start → FSM stays in WAIT_DROP; no second dp_start until finished drops and rises.
- HOST_PRIORITY_EN defined, host_req held continuously for 5 instructions → 5 consecutive host grants, zero plots; host_req released → scanning resumes at the frozen pixel.
